// File: rtl/baud_tick_generator_frac.sv
// Programmable UART baud/oversample/mid-bit tick source with glitch-free divisor reload.
// Define BAUD_GEN_FRAC_EN to build the fractional-divisor accumulator; otherwise P = D always.
module baud_tick_generator_frac #(
  parameter int CLOCK_FREQ = 50000000,
  parameter int BAUD_RATE  = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int DIV_W      = 16,
  parameter int FRAC_W     = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            en,
  input  logic                            restart,
  input  logic                            div_wr,
  input  logic [DIV_W+FRAC_W-1:0]         div_in,
  output logic                            div_pending,
  output logic                            os_tick,
  output logic                            mid_tick,
  output logic                            baud_tick,
  output logic [$clog2(OVERSAMPLE)-1:0]   os_cnt
);

  localparam int OS_W  = $clog2(OVERSAMPLE);
  localparam int DIN_W = DIV_W + FRAC_W;
  localparam longint RST_NUM   = longint'(CLOCK_FREQ) * (longint'(1) << FRAC_W);
  localparam longint RST_DEN   = longint'(BAUD_RATE) * longint'(OVERSAMPLE);
  localparam longint RST_DIV_L = (2 * RST_NUM + RST_DEN) / (2 * RST_DEN);
  localparam logic [DIN_W-1:0] RST_DIV    = DIN_W'(RST_DIV_L);
  localparam logic [OS_W-1:0]  OS_LAST    = OS_W'(OVERSAMPLE - 1);
  localparam logic [OS_W-1:0]  OS_MID_M1  = OS_W'(OVERSAMPLE / 2 - 1);

  logic [DIN_W-1:0] active_div;
  logic [DIN_W-1:0] pending_div;
  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] d_eff;
  logic [DIV_W:0]   p_last;
  logic             wrap_q;
  logic             tick_set;
  logic             apply;

`ifdef BAUD_GEN_FRAC_EN
  logic [FRAC_W-1:0] acc;
  logic              carry_q;
`else
  logic              frac_unused;
  assign frac_unused = ^active_div[FRAC_W-1:0];
`endif

  always_comb begin
    d_eff = active_div[DIN_W-1:FRAC_W];
    if (d_eff < DIV_W'(2)) d_eff = DIV_W'(2);
`ifdef BAUD_GEN_FRAC_EN
    p_last = {1'b0, d_eff} + {{DIV_W{1'b0}}, carry_q} - (DIV_W+1)'(1);
`else
    p_last = {1'b0, d_eff} - (DIV_W+1)'(1);
`endif
  end

  // wrap_q marks the last cycle of a period so a divisor change during it cannot stretch it
  assign tick_set = !wrap_q && (({1'b0, cnt} + (DIV_W+1)'(1)) >= p_last);
  assign apply    = restart || !en || (tick_set && (os_cnt == OS_LAST));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      wrap_q    <= 1'b0;
      os_cnt    <= '0;
      os_tick   <= 1'b0;
      mid_tick  <= 1'b0;
      baud_tick <= 1'b0;
    end else if (restart) begin
      cnt       <= '0;
      wrap_q    <= 1'b0;
      os_cnt    <= '0;
      os_tick   <= 1'b0;
      mid_tick  <= 1'b0;
      baud_tick <= 1'b0;
    end else if (!en) begin
      os_tick   <= 1'b0;
      mid_tick  <= 1'b0;
      baud_tick <= 1'b0;
    end else begin
      os_tick   <= tick_set;
      mid_tick  <= tick_set && (os_cnt == OS_MID_M1);
      baud_tick <= tick_set && (os_cnt == OS_LAST);
      wrap_q    <= tick_set;
      cnt       <= wrap_q ? '0 : cnt + DIV_W'(1);
      if (tick_set) os_cnt <= (os_cnt == OS_LAST) ? '0 : os_cnt + OS_W'(1);
    end
  end

  // a write on an apply edge is captured but waits for the next apply point
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_div  <= RST_DIV;
      pending_div <= RST_DIV;
      div_pending <= 1'b0;
    end else begin
      if (apply && div_pending) active_div <= pending_div;
      if (div_wr) begin
        pending_div <= div_in;
        div_pending <= 1'b1;
      end else if (apply) begin
        div_pending <= 1'b0;
      end
    end
  end

`ifdef BAUD_GEN_FRAC_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      carry_q <= 1'b0;
    end else if (restart) begin
      acc     <= '0;
      carry_q <= 1'b0;
    end else if (en && tick_set) begin
      {carry_q, acc} <= (FRAC_W+1)'(acc) + (FRAC_W+1)'(active_div[FRAC_W-1:0]);
    end
  end
`endif

endmodule

// File: tb/tb_baud_tick_generator_frac.sv
// Directed bench for baud_tick_generator_frac at 1600 Hz / 100 baud / x4 (reset divisor 4.0).
// Wait counts are edges after the reference edge; a pulse raised by edge k occupies cycle k.
module tb_baud_tick_generator_frac;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        restart = 1'b0;
  logic        div_wr = 1'b0;
  logic [19:0] div_in = '0;
  logic        div_pending, os_tick, mid_tick, baud_tick;
  logic [1:0]  os_cnt;
  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  baud_tick_generator_frac #(
    .CLOCK_FREQ(1600), .BAUD_RATE(100), .OVERSAMPLE(4), .DIV_W(16), .FRAC_W(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .restart(restart), .div_wr(div_wr),
    .div_in(div_in), .div_pending(div_pending), .os_tick(os_tick),
    .mid_tick(mid_tick), .baud_tick(baud_tick), .os_cnt(os_cnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic sig(input int sel);
    return (sel == 0) ? os_tick : (sel == 1) ? mid_tick : baud_tick;
  endfunction

  // n = edges until the selected tick is seen; limit+1 on timeout
  task automatic wait_sig(input int sel, input int limit, output int n);
    n = 0;
    forever begin
      step();
      n++;
      if (sig(sel) || n > limit) break;
    end
  endtask

  task automatic load_and_restart(input logic [19:0] d);
    div_in = d; div_wr = 1'b1; step(); div_wr = 1'b0;
    restart = 1'b1; step(); restart = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0;
    step(); step();
    tests_run++;
    if ({os_tick, mid_tick, baud_tick} !== 3'b000) begin
      tests_failed++; $display("FAIL reset_ticks got=%b want=000", {os_tick, mid_tick, baud_tick});
    end
    tests_run++;
    if (os_cnt !== 2'd0) begin tests_failed++; $display("FAIL reset_os_cnt got=%0d want=0", os_cnt); end
    tests_run++;
    if (div_pending !== 1'b0) begin tests_failed++; $display("FAIL reset_pending got=%b want=0", div_pending); end
  endtask

  task automatic test_basic();
    int n;
    int exp_os[3] = '{3, 4, 4};
    en = 1'b1; rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wait_sig(0, 20, n);
      tests_run++;
      if (n !== exp_os[i]) begin tests_failed++; $display("FAIL basic_os_spacing[%0d] got=%0d want=%0d", i, n, exp_os[i]); end
    end
    wait_sig(2, 20, n);
    tests_run++;
    if (n !== 4) begin tests_failed++; $display("FAIL basic_first_baud got=%0d want=4", n); end
    wait_sig(1, 20, n);
    tests_run++;
    if (n !== 8) begin tests_failed++; $display("FAIL basic_baud_to_mid got=%0d want=8", n); end
    tests_run++;
    if (os_cnt !== 2'd2) begin tests_failed++; $display("FAIL basic_mid_os_cnt got=%0d want=2", os_cnt); end
    wait_sig(2, 20, n);
    tests_run++;
    if (n !== 8) begin tests_failed++; $display("FAIL basic_mid_to_baud got=%0d want=8", n); end
    tests_run++;
    if ({os_tick, os_cnt} !== 3'b100) begin
      tests_failed++; $display("FAIL basic_baud_coincident got=%b want=100", {os_tick, os_cnt});
    end
  endtask

  task automatic test_frac();
    int n;
`ifdef BAUD_GEN_FRAC_EN
    int exp_sp[3] = '{4, 5, 4};
    int exp_baud = 18;
`else
    int exp_sp[3] = '{4, 4, 4};
    int exp_baud = 16;
`endif
    load_and_restart({16'd4, 4'd8});
    wait_sig(0, 20, n);
    tests_run++;
    if (n !== 3) begin tests_failed++; $display("FAIL frac_first_os got=%0d want=3", n); end
    for (int i = 0; i < 3; i++) begin
      wait_sig(0, 20, n);
      tests_run++;
      if (n !== exp_sp[i]) begin tests_failed++; $display("FAIL frac_spacing[%0d] got=%0d want=%0d", i, n, exp_sp[i]); end
    end
    tests_run++;
    if (baud_tick !== 1'b1) begin tests_failed++; $display("FAIL frac_baud_at_4th got=%b want=1", baud_tick); end
    wait_sig(2, 40, n);
    tests_run++;
    if (n !== exp_baud) begin tests_failed++; $display("FAIL frac_baud_period got=%0d want=%0d", n, exp_baud); end
  endtask

  task automatic test_div_change();
    int n;
    load_and_restart({16'd4, 4'd0});
    wait_sig(0, 20, n);
    step();
    div_in = {16'd6, 4'd0}; div_wr = 1'b1; step(); div_wr = 1'b0;
    tests_run++;
    if (div_pending !== 1'b1) begin tests_failed++; $display("FAIL divchg_pending_set got=%b want=1", div_pending); end
    wait_sig(2, 30, n);
    tests_run++;
    if (n !== 10) begin tests_failed++; $display("FAIL divchg_old_period got=%0d want=10", n); end
    tests_run++;
    if (div_pending !== 1'b0) begin tests_failed++; $display("FAIL divchg_pending_clr got=%b want=0", div_pending); end
    for (int i = 0; i < 2; i++) begin
      wait_sig(0, 20, n);
      tests_run++;
      if (n !== 6) begin tests_failed++; $display("FAIL divchg_new_spacing[%0d] got=%0d want=6", i, n); end
    end
  endtask

  task automatic test_restart();
    int n;
    load_and_restart({16'd4, 4'd0});
    wait_sig(0, 20, n);
    step(); step();
    restart = 1'b1; step(); restart = 1'b0;
    tests_run++;
    if ({os_tick, os_cnt} !== 3'b000) begin
      tests_failed++; $display("FAIL restart_state got=%b want=000", {os_tick, os_cnt});
    end
    wait_sig(0, 20, n);
    tests_run++;
    if (n !== 3) begin tests_failed++; $display("FAIL restart_first_os got=%0d want=3", n); end
    tests_run++;
    if (os_cnt !== 2'd1) begin tests_failed++; $display("FAIL restart_os_cnt got=%0d want=1", os_cnt); end
  endtask

  task automatic test_en_hold();
    int n;
    load_and_restart({16'd4, 4'd0});
    wait_sig(0, 20, n);
    step(); step();
    div_in = '0; div_wr = 1'b1; step(); div_wr = 1'b0;
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      tests_run++;
      if ({os_tick, mid_tick, baud_tick, os_cnt} !== 5'b00001) begin
        tests_failed++; $display("FAIL en_hold[%0d] got=%b want=00001", i, {os_tick, mid_tick, baud_tick, os_cnt});
      end
    end
    tests_run++;
    if (div_pending !== 1'b0) begin tests_failed++; $display("FAIL en_apply got=%b want=0", div_pending); end
    en = 1'b1;
    wait_sig(0, 20, n);
    tests_run++;
    if (n !== 1) begin tests_failed++; $display("FAIL en_resume_first got=%0d want=1", n); end
    tests_run++;
    if (os_cnt !== 2'd2) begin tests_failed++; $display("FAIL en_resume_os_cnt got=%0d want=2", os_cnt); end
    for (int i = 0; i < 2; i++) begin
      wait_sig(0, 20, n);
      tests_run++;
      if (n !== 2) begin tests_failed++; $display("FAIL en_clamp_spacing[%0d] got=%0d want=2", i, n); end
    end
  endtask

  task automatic test_back_to_back();
    int n;
    div_in = {16'd7, 4'd0}; div_wr = 1'b1; step();
    div_in = {16'd3, 4'd0}; step(); div_wr = 1'b0;
    restart = 1'b1; step(); restart = 1'b0;
    wait_sig(0, 20, n);
    tests_run++;
    if (n !== 2) begin tests_failed++; $display("FAIL lastwins_first got=%0d want=2", n); end
    wait_sig(0, 20, n);
    tests_run++;
    if (n !== 3) begin tests_failed++; $display("FAIL lastwins_spacing got=%0d want=3", n); end

    load_and_restart({16'd4, 4'd0});
    repeat (14) step();
    div_in = {16'd5, 4'd0}; div_wr = 1'b1; step(); div_wr = 1'b0;
    tests_run++;
    if ({baud_tick, div_pending} !== 2'b11) begin
      tests_failed++; $display("FAIL wr_at_baud got=%b want=11", {baud_tick, div_pending});
    end
    wait_sig(2, 30, n);
    tests_run++;
    if (n !== 16) begin tests_failed++; $display("FAIL wr_at_baud_period got=%0d want=16", n); end
    tests_run++;
    if (div_pending !== 1'b0) begin tests_failed++; $display("FAIL wr_at_baud_clr got=%b want=0", div_pending); end
    wait_sig(0, 20, n);
    tests_run++;
    if (n !== 5) begin tests_failed++; $display("FAIL wr_at_baud_spacing got=%0d want=5", n); end

    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if ({os_tick, mid_tick, baud_tick, os_cnt, div_pending} !== 6'b000000) begin
      tests_failed++;
      $display("FAIL async_reset got=%b want=000000", {os_tick, mid_tick, baud_tick, os_cnt, div_pending});
    end
    step();
    rst_n = 1'b1;
    wait_sig(0, 20, n);
    tests_run++;
    if (n !== 3) begin tests_failed++; $display("FAIL reset_div_restored got=%0d want=3", n); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_frac();
    test_div_change();
    test_restart();
    test_en_hold();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1, "timeout");
  end
endmodule
